pll_phase_ctrl: RTL
===================

// Module: pll_phase_ctrl
// PURPOSE
//  Sequences dynamic phase stepping of the ECP5 EHXPLLL (PHASESEL/PHASEDIR/PHASESTEP).
//  Accepts step requests (output select, direction, count) from a host or training FSM.
//  Generates pulses that meet PLL setup/hold requirements, then confirms PLL lock.
//  Runs on the free-running board oscillator, never on a PLL output. Sits beside clk_gen.
// PARAMETERS
//  STEP_W       4     width of req_steps; max steps per request = 2**STEP_W-1
//  SETUP_CYC    4     cycles PHASESEL/PHASEDIR are stable before the first PHASESTEP (>=1)
//  PULSE_CYC    4     cycles PHASESTEP is held high, and then low, per step (>=1; >=4 VCO cycles)
//  SETTLE_CYC   16    minimum wait after the last step before lock is checked (>=1)
//  LOCK_TIMEOUT 1024  max cycles in SETTLE waiting for lock before reporting an error
//  POS_W        5     width of each phase-position counter (PLL_PHASE_TRACK_EN only)
// PORTS
//  clk_in       in   1       free-running reference clock
//  rst          in   1       synchronous, active-high reset
//  pll_lock     in   1       raw PLL LOCK, asynchronous; 2-FF synchronised inside to lock_s
//  req_valid    in   1       step request valid
//  req_ready    out  1       = (state==IDLE) && lock_s
//  req_sel      in   2       PHASESEL code: 00 CLKOS, 01 CLKOS2, 10 CLKOS3, 11 CLKOP
//  req_dir      in   1       0 = delay (lag), 1 = advance
//  req_steps    in   STEP_W  number of PHASESTEP pulses
//  phasesel     out  2       to PLL PHASESEL[1:0]
//  phasedir     out  1       to PLL PHASEDIR
//  phasestep    out  1       to PLL PHASESTEP; idle low
//  busy         out  1       high in every state except IDLE
//  done         out  1       1-cycle pulse when a request completes
//  err          out  1       valid with done; 1 = lock lost during stepping or lock timeout
//  steps_done   out  STEP_W  completed pulses of the last request; valid with done
//  phase_pos    out  4*POS_W per-select position, [sel*POS_W +: POS_W] (PLL_PHASE_TRACK_EN only)
// BEHAVIOUR
//  Reset: all outputs 0, including req_ready (lock_s sync is cleared). State is IDLE. Counters are 0.
//  FSM states: IDLE, SETUP, STEP_HI, STEP_LO, SETTLE, DONE.
//  IDLE: a handshake (req_valid && req_ready) latches sel/dir/steps. Next cycle:
//    steps==0 -> DONE (err=0, steps_done=0).
//    otherwise -> SETUP.
//  phasesel/phasedir drive the latched values from SETUP through SETTLE. Both hold their last value in IDLE.
//  SETUP: SETUP_CYC cycles, then STEP_HI.
//  STEP_HI: phasestep=1 for PULSE_CYC cycles, then STEP_LO.
//  STEP_LO: phasestep=0 for PULSE_CYC cycles. Then steps_done increments.
//    If steps_done reaches the request count -> SETTLE; else -> STEP_HI.
//  Lock drop (lock_s==0) in SETUP/STEP_HI/STEP_LO: the FSM goes to SETTLE on the next cycle.
//    phasestep is forced low on that cycle. A partial pulse is not counted. err_flag is set.
//  SETTLE: wait at least SETTLE_CYC cycles, then leave on the first cycle with lock_s==1.
//    If cycles in SETTLE reach LOCK_TIMEOUT, set err_flag and leave anyway.
//  DONE: done=1, err=err_flag, steps_done is valid. Next cycle -> IDLE; err_flag clears.
//  Latency for N>0 steps with no errors: SETUP_CYC + 2*PULSE_CYC*N + SETTLE_CYC + 1 cycles,
//    counted from the handshake cycle to the done cycle.
//  req_valid while busy is ignored (ready low). req_* need not stay stable after the handshake.
//  rst mid-sequence: the next edge returns to IDLE with phasestep=0. The PLL is left at the partial phase.
//  Cycle counters are sized $clog2(max(param)+1). No counter wraps except phase_pos.
// CONFIGURATION
//  PLL_PHASE_TRACK_EN defined:
//    phase_pos[sel] changes by +1 per completed pulse if dir==0, -1 if dir==1.
//    It wraps modulo 2**POS_W. Reset value is 0.
//  PLL_PHASE_TRACK_EN undefined: phase_pos port and counters are absent. All other behaviour is identical.
// STRUCTURE
//  pll_ctrl_pkg holds: state_t enum, PHASESEL code localparams (SEL_CLKOS..SEL_CLKOP), DIR_DELAY/DIR_ADVANCE.
//  Sub-module lock_sync: 2-FF synchroniser (clk_in, rst, d, q). It is reused for other async status inputs.
// TESTING
//  (Bench parameters: SETUP_CYC=2, PULSE_CYC=2, SETTLE_CYC=4, LOCK_TIMEOUT=32, pll_lock tied high.)
//  1 Release rst, pll_lock=1 -> req_ready rises 2 cycles later. All outputs were 0 during reset.
//  2 sel=01, dir=0, steps=3 -> phasesel=01 for 2 cycles before the first pulse; exactly 3 pulses, 2 high / 2 low;
//    done at cycle 19 after handshake; err=0; steps_done=3; phase_pos[1]=3 (TRACK_EN).
//  3 steps=0 -> no phasestep activity; done 1 cycle after handshake; err=0; steps_done=0.
//  4 sel=11, dir=1, steps=5: drop pll_lock during pulse 3 and restore it 10 cycles later
//    -> phasestep low within 3 cycles; done with err=1; steps_done=2; phase_pos[3]=-2 mod 32 = 30.
//  5 pll_lock held low after a drop -> done with err=1 exactly 32 cycles after SETTLE entry.
//    req_ready stays 0 until lock returns.
//  6 Assert rst during STEP_HI of a 7-step request -> next cycle: phasestep=0, busy=0, IDLE; no done pulse.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// Shared types and codes for the ECP5 EHXPLLL dynamic phase-step controller.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STEP_HI,
        STEP_LO,
        SETTLE,
        DONE
    } state_t;

    // PHASESEL codes as decoded by the EHXPLLL
    localparam logic [1:0] SEL_CLKOS  = 2'b00;
    localparam logic [1:0] SEL_CLKOS2 = 2'b01;
    localparam logic [1:0] SEL_CLKOS3 = 2'b10;
    localparam logic [1:0] SEL_CLKOP  = 2'b11;

    localparam logic DIR_DELAY   = 1'b0;
    localparam logic DIR_ADVANCE = 1'b1;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/lock_sync.sv
// Two-flop synchroniser for asynchronous status inputs (PLL lock and similar).
module lock_sync (
    input  logic clk_in,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state always uses non-blocking <= so every flop samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_phase_ctrl.sv
// Sequences EHXPLLL PHASESEL/PHASEDIR/PHASESTEP pulses and confirms lock afterwards.
// Optional per-output phase tracking is compiled in with `define PLL_PHASE_TRACK_EN.
module pll_phase_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int STEP_W       = 4,
    parameter int SETUP_CYC    = 4,
    parameter int PULSE_CYC    = 4,
    parameter int SETTLE_CYC   = 16,
    parameter int LOCK_TIMEOUT = 1024,
    parameter int POS_W        = 5
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              pll_lock,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_sel,
    input  logic              req_dir,
    input  logic [STEP_W-1:0] req_steps,
    output logic [1:0]        phasesel,
    output logic              phasedir,
    output logic              phasestep,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [STEP_W-1:0] steps_done
`ifdef PLL_PHASE_TRACK_EN
   ,output logic [4*POS_W-1:0] phase_pos
`endif
);

    localparam int CYC_MAX = max_of4(SETUP_CYC, PULSE_CYC, SETTLE_CYC, LOCK_TIMEOUT);
    localparam int CYC_W   = $clog2(CYC_MAX + 1);

    localparam logic [CYC_W-1:0] SETUP_LAST   = CYC_W'(SETUP_CYC - 1);
    localparam logic [CYC_W-1:0] PULSE_LAST   = CYC_W'(PULSE_CYC - 1);
    localparam logic [CYC_W-1:0] SETTLE_LAST  = CYC_W'(SETTLE_CYC - 1);
    localparam logic [CYC_W-1:0] TIMEOUT_LAST = CYC_W'(LOCK_TIMEOUT - 1);

    state_t              state;
    logic                lock_s;
    logic [CYC_W-1:0]    cyc_cnt;
    logic [STEP_W-1:0]   req_cnt;
    logic                err_flag;

    lock_sync u_lock_sync (
        .clk_in (clk_in),
        .rst    (rst),
        .d      (pll_lock),
        .q      (lock_s)
    );

    assign req_ready = (state == IDLE) && lock_s;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state      <= IDLE;
            cyc_cnt    <= '0;
            req_cnt    <= '0;
            err_flag   <= 1'b0;
            phasesel   <= 2'b00;
            phasedir   <= 1'b0;
            phasestep  <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            steps_done <= '0;
`ifdef PLL_PHASE_TRACK_EN
            phase_pos  <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;

            // Losing lock mid-sequence abandons the request; any partial pulse is not counted
            if ((state inside {SETUP, STEP_HI, STEP_LO}) && !lock_s) begin
                state     <= SETTLE;
                cyc_cnt   <= '0;
                phasestep <= 1'b0;
                err_flag  <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (req_valid && req_ready) begin
                            req_cnt    <= req_steps;
                            steps_done <= '0;
                            cyc_cnt    <= '0;
                            err_flag   <= 1'b0;
                            if (req_steps == '0) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                phasesel <= req_sel;
                                phasedir <= req_dir;
                                state    <= SETUP;
                            end
                        end
                    end

                    SETUP: begin
                        if (cyc_cnt == SETUP_LAST) begin
                            cyc_cnt   <= '0;
                            phasestep <= 1'b1;
                            state     <= STEP_HI;
                        end else begin
                            cyc_cnt <= cyc_cnt + 1'b1;
                        end
                    end

                    STEP_HI: begin
                        if (cyc_cnt == PULSE_LAST) begin
                            cyc_cnt   <= '0;
                            phasestep <= 1'b0;
                            state     <= STEP_LO;
                        end else begin
                            cyc_cnt <= cyc_cnt + 1'b1;
                        end
                    end

                    STEP_LO: begin
                        if (cyc_cnt == PULSE_LAST) begin
                            cyc_cnt    <= '0;
                            steps_done <= steps_done + 1'b1;
`ifdef PLL_PHASE_TRACK_EN
                            if (phasedir == DIR_DELAY)
                                phase_pos[int'(phasesel)*POS_W +: POS_W] <=
                                    phase_pos[int'(phasesel)*POS_W +: POS_W] + POS_W'(1);
                            else
                                phase_pos[int'(phasesel)*POS_W +: POS_W] <=
                                    phase_pos[int'(phasesel)*POS_W +: POS_W] - POS_W'(1);
`endif
                            if (steps_done == req_cnt - STEP_W'(1)) begin
                                state <= SETTLE;
                            end else begin
                                phasestep <= 1'b1;
                                state     <= STEP_HI;
                            end
                        end else begin
                            cyc_cnt <= cyc_cnt + 1'b1;
                        end
                    end

                    SETTLE: begin
                        if (lock_s && (cyc_cnt >= SETTLE_LAST)) begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= err_flag;
                        end else if (cyc_cnt == TIMEOUT_LAST) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            err      <= 1'b1;
                            err_flag <= 1'b1;
                        end else begin
                            cyc_cnt <= cyc_cnt + 1'b1;
                        end
                    end

                    DONE: begin
                        err_flag <= 1'b0;
                        state    <= IDLE;
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifndef PLL_PHASE_TRACK_EN
    // POS_W only sizes the tracking counters; keep it referenced when they are compiled out
    logic unused_pos_w;
    assign unused_pos_w = (POS_W > 0);
`else
`endif

endmodule
